// File: rtl/bit_serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package bit_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must index WIDTH bit positions; never narrower than one bit.
    function automatic int counter_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Optional port V exists when BIT_SERIAL_SUB_OVERFLOW_EN is defined.
interface bit_serial_subtractor_if
    import bit_serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             busy;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic             V;
`endif

    modport master (
        output in_valid, A, B, Bin, out_ready,
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        input  V,
`endif
        input  in_ready, out_valid, Diff, Bout, busy
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        output V,
`endif
        output in_ready, out_valid, Diff, Bout, busy
    );

endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial A - B - Bin using one full-subtractor cell, LSB first over WIDTH cycles.
// Define BIT_SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output V.
module bit_serial_subtractor
    import bit_serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic                    clk,
    input  logic                    rst,
    bit_serial_subtractor_if.slave  bus
);

    localparam int             CW   = counter_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow;
    logic             cell_d;
    logic             cell_bout;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    logic             v_reg;
`endif

    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)    state_next = SHIFT;
            SHIFT:   if (count == LAST)   state_next = DONE;
            DONE:    if (bus.out_ready)   state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
            v_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.A;
                        b_sr   <= bus.B;
                        borrow <= bus.Bin;
                        count  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
                    borrow  <= cell_bout;
                    count   <= count + 1'b1;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
                    // Overflow is borrow into the MSB xor borrow out of it.
                    if (count == LAST) begin
                        v_reg <= borrow ^ cell_bout;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.Diff      = diff_sr;
    assign bus.Bout      = borrow;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
    assign bus.V         = v_reg;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: vector table, corner sequences, random ops.
// Define BIT_SERIAL_SUB_OVERFLOW_EN to also check V.
module tb_bit_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       v;
    } vector_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference result from plain integer arithmetic: {V, Bout, Diff}.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   ud;
        int   sd;
        logic v;
        logic [7:0] d;
        ud = int'(a) - int'(b) - int'(bin);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        v  = (sd > 127) || (sd < -128);
        d  = ud[7:0];
        return {v, (ud < 0), d};
    endfunction

    // Presents one operand set, returns edges from handshake edge (inclusive) to out_valid.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                  output int latency);
        int n;
        n = 0;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        latency = 1;
        while (!bus.out_valid && latency < 50) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] diff, input logic bout, input logic v);
        check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, " Diff"}, 32'(bus.Diff), 32'(diff));
        check({name, " Bout"}, 32'(bus.Bout), 32'(bout));
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        check({name, " V"}, 32'(bus.V), 32'(v));
`else
        if (v === 1'bx) $display("[TB] note: unexpected X in V expectation for %s", name);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, " in_ready after release"}, 32'(bus.in_ready), 32'd1);
        check({name, " out_valid after release"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vector_t     vectors[7];
        logic [9:0]  expected;
        logic [9:0]  q[$];
        int          latency;
        int          valid_seen;
        int          idx;
        int          results;
        int          cyc;
        int          last_cyc;
        logic        hs_in;
        logic        hs_out;
        logic [7:0]  ops_a[3];
        logic [7:0]  ops_b[3];
        logic        ops_bin[3];
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rbin;
        logic [7:0]  sample_diff;
        logic        sample_bout;

        checks = 0;
        errors = 0;

        vectors[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vectors[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vectors[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vectors[3] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
        vectors[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vectors[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vectors[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset Diff", 32'(bus.Diff), 32'd0);
        check("reset Bout", 32'(bus.Bout), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
        check("reset V", 32'(bus.V), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vectors[i].a, vectors[i].b, vectors[i].bin, latency);
            check($sformatf("vec%0d latency", i), 32'(latency), 32'(WIDTH + 1));
            check_output($sformatf("vec%0d", i), vectors[i].diff, vectors[i].bout, vectors[i].v);
        end

        // Backpressure: result must hold while the consumer stalls.
        apply_stimulus(8'h10, 8'h01, 1'b0, latency);
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall Diff", 32'(bus.Diff), 32'h0F);
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            check("stall busy", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        check_output("stall release", 8'h0F, 1'b0, 1'b0);

        // Reset three edges into SHIFT aborts the operation at once.
        bus.A        = 8'h33;
        bus.B        = 8'h11;
        bus.Bin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-abort busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort Diff", 32'(bus.Diff), 32'd0);
        check("abort Bout", 32'(bus.Bout), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) valid_seen++;
        end
        check("abort no out_valid", 32'(valid_seen), 32'd0);
        apply_stimulus(8'hAA, 8'h55, 1'b0, latency);
        check_output("post-abort", 8'h55, 1'b0, 1'b1);

        // Back-to-back: in_valid held with three operand sets, out_ready high.
        ops_a[0] = 8'h12; ops_b[0] = 8'h34; ops_bin[0] = 1'b0;
        ops_a[1] = 8'hC8; ops_b[1] = 8'h07; ops_bin[1] = 1'b1;
        ops_a[2] = 8'h01; ops_b[2] = 8'h01; ops_bin[2] = 1'b1;
        idx           = 0;
        results       = 0;
        cyc           = 0;
        last_cyc      = -1;
        bus.out_ready = 1'b1;
        bus.A         = ops_a[0];
        bus.B         = ops_b[0];
        bus.Bin       = ops_bin[0];
        bus.in_valid  = 1'b1;
        while (results < 3 && cyc < 100) begin
            hs_in       = bus.in_valid && bus.in_ready;
            hs_out      = bus.out_valid && bus.out_ready;
            sample_diff = bus.Diff;
            sample_bout = bus.Bout;
            if (hs_in) q.push_back(ref_sub(bus.A, bus.B, bus.Bin));
            @(posedge clk); #1;
            cyc++;
            if (hs_out) begin
                if (q.size() > 0) begin
                    expected = q.pop_front();
                    check("b2b Diff", 32'(sample_diff), 32'(expected[7:0]));
                    check("b2b Bout", 32'(sample_bout), 32'(expected[8]));
                end else begin
                    check("b2b unexpected result", 32'd1, 32'd0);
                end
                if (last_cyc >= 0) check("b2b spacing", 32'(cyc - last_cyc), 32'd10);
                last_cyc = cyc;
                results++;
            end
            if (hs_in) begin
                idx++;
                if (idx < 3) begin
                    bus.A   = ops_a[idx];
                    bus.B   = ops_b[idx];
                    bus.Bin = ops_bin[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("b2b result count", 32'(results), 32'd3);
        bus.in_valid = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) valid_seen++;
        end
        check("b2b no extra result", 32'(valid_seen), 32'd0);
        bus.out_ready = 1'b0;

        // Randomized operations against the integer reference.
        for (int i = 0; i < 20; i++) begin
            ra       = 8'($urandom);
            rb       = 8'($urandom);
            rbin     = 1'($urandom);
            expected = ref_sub(ra, rb, rbin);
            apply_stimulus(ra, rb, rbin, latency);
            check("rand latency", 32'(latency), 32'(WIDTH + 1));
            check_output($sformatf("rand %0h-%0h-%0d", ra, rb, rbin), expected[7:0], expected[8], expected[9]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
